// File: rtl/udp_shift_ctrl.sv
// Delay-line controller for an external dynamic-latency shift register.
// Tracks valid/last beside the data and drains the line before any delay change.
module udp_shift_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_DEPTH   = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int RESET_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cfg_depth,
    input  logic                  cfg_load,
    output logic                  cfg_busy,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] sr_din,
    output logic [ADDR_WIDTH-1:0] sr_addr,
    input  logic [DATA_WIDTH-1:0] sr_dout,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_MAX = ADDR_WIDTH'(MAX_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_RST = ADDR_WIDTH'(RESET_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_MAX   = (ADDR_WIDTH + 1)'(MAX_DEPTH);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] pend;
    logic [ADDR_WIDTH-1:0] depth_req;
    logic [ADDR_WIDTH:0]   inflight;
    logic [MAX_DEPTH-1:0]  vchain;
    logic [MAX_DEPTH-1:0]  lchain;
    logic                  accept;
    logic                  tap_v;
    logic                  tap_l;

    assign s_ready   = (state == ST_RUN);
    assign cfg_busy  = ~s_ready;
    assign accept    = s_valid & s_ready;
    assign sr_din    = accept ? s_data : '0;
    assign depth_req = (cfg_depth > DEPTH_MAX) ? DEPTH_MAX : cfg_depth;

    // Tap mux written as a compare loop so sr_addr may be wider than the chain.
    always_comb begin
        tap_v = 1'b0;
        tap_l = 1'b0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (sr_addr == ADDR_WIDTH'(i)) begin
                tap_v = vchain[i];
                tap_l = lchain[i];
            end
        end
    end

    assign m_valid = tap_v;
    assign m_last  = tap_v & tap_l;
    assign m_data  = tap_v ? sr_dout : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            sr_addr  <= DEPTH_RST;
            pend     <= DEPTH_RST;
            inflight <= '0;
            vchain   <= '0;
            lchain   <= '0;
        end else begin
            vchain <= (vchain << 1) | MAX_DEPTH'(accept);
            lchain <= (lchain << 1) | MAX_DEPTH'(accept & s_last);

            if (accept && !m_valid)
                inflight <= inflight + 1'b1;
            else if (!accept && m_valid)
                inflight <= inflight - 1'b1;

            case (state)
                ST_RUN: begin
                    if (cfg_load) begin
                        pend  <= depth_req;
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cfg_load)
                        pend <= depth_req;
                    if (inflight == '0)
                        state <= ST_APPLY;
                end
                ST_APPLY: begin
                    // Line is empty here, so the new tap never splits a beat.
                    sr_addr <= pend;
                    vchain  <= '0;
                    lchain  <= '0;
                    if (cfg_load) begin
                        pend  <= depth_req;
                        state <= ST_DRAIN;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(accept && !m_valid && inflight == CNT_MAX));
            assert (!(m_valid && !accept && inflight == '0));
        end
    end

endmodule

// File: tb/tb_udp_shift_ctrl.sv
// Randomised bench for udp_shift_ctrl against a queue-based latency model,
// with a behavioural shift register hanging off the sr_* port.
module tb_udp_shift_ctrl;

    localparam int DW   = 8;
    localparam int MAXD = 8;
    localparam int AW   = 4;
    localparam int RD   = 8;
    localparam int M_RUN = 0, M_DRAIN = 1, M_APPLY = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cfg_depth;
    logic          cfg_load;
    logic          cfg_busy;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] sr_din;
    logic [AW-1:0] sr_addr;
    logic [DW-1:0] sr_dout;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;

    udp_shift_ctrl #(.DATA_WIDTH(DW), .MAX_DEPTH(MAXD), .ADDR_WIDTH(AW), .RESET_DEPTH(RD)) dut (
        .clk(clk), .rst(rst), .cfg_depth(cfg_depth), .cfg_load(cfg_load), .cfg_busy(cfg_busy),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .sr_din(sr_din), .sr_addr(sr_addr), .sr_dout(sr_dout),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // External shift register: tap k is sr_din delayed k+1 cycles.
    logic [DW-1:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    always @(posedge clk) begin
        for (int i = 15; i > 0; i--) mem[i] <= mem[i-1];
        mem[0] <= sr_din;
    end
    assign sr_dout = mem[sr_addr];

    typedef struct { int t; logic [7:0] d; logic l; } ent_t;
    ent_t q[$];
    int   cyc, mode, m_addr, m_pend;
    int   nchk, nerr;
    logic          obs_v [int];
    logic [DW-1:0] obs_d [int];
    logic          obs_l [int];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int clampd(input logic [AW-1:0] dp);
        return (int'(dp) > MAXD - 1) ? MAXD - 1 : int'(dp);
    endfunction

    task automatic step(input logic r, input logic sv, input logic [7:0] sd, input logic sl,
                        input logic ld, input logic [AW-1:0] dp);
        int   n;
        logic ev, acc;
        logic [7:0] ed;
        logic el;
        rst = r; s_valid = sv; s_data = sd; s_last = sl; cfg_load = ld; cfg_depth = dp;
        #1;
        n   = q.size();
        ev  = (n > 0) && (q[0].t == cyc);
        ed  = ev ? q[0].d : 8'h00;
        el  = ev ? q[0].l : 1'b0;
        acc = sv && (mode == M_RUN);
        chk("m_valid",  32'(m_valid),  32'(ev));
        chk("m_data",   32'(m_data),   32'(ed));
        chk("m_last",   32'(m_last),   32'(el));
        chk("s_ready",  32'(s_ready),  32'(mode == M_RUN));
        chk("cfg_busy", 32'(cfg_busy), 32'(mode != M_RUN));
        chk("sr_addr",  32'(sr_addr),  32'(m_addr));
        chk("sr_din",   32'(sr_din),   32'(acc ? sd : 8'h00));
        obs_v[cyc] = m_valid; obs_d[cyc] = m_data; obs_l[cyc] = m_last;
        if (ev) void'(q.pop_front());
        if (r) begin
            mode = M_RUN; m_addr = RD - 1; m_pend = RD - 1; q.delete();
        end else begin
            case (mode)
                M_RUN: begin
                    if (acc) q.push_back('{t: cyc + m_addr + 1, d: sd, l: sl});
                    if (ld) begin m_pend = clampd(dp); mode = M_DRAIN; end
                end
                M_DRAIN: begin
                    if (ld) m_pend = clampd(dp);
                    if (n == 0) mode = M_APPLY;
                end
                default: begin
                    m_addr = m_pend;
                    if (ld) begin m_pend = clampd(dp); mode = M_DRAIN; end
                    else mode = M_RUN;
                end
            endcase
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 8'h00, 0, 0, '0);
    endtask

    initial begin
        int c0, c_ld, ca, n, cnt;
        nchk = 0; nerr = 0; cyc = 0;
        rst = 1; s_valid = 0; s_data = '0; s_last = 0; cfg_load = 0; cfg_depth = '0;
        repeat (2) @(posedge clk);
        #1;
        mode = M_RUN; m_addr = RD - 1; m_pend = RD - 1;

        // Reset state is checked by the first model step; three back-to-back beats.
        c0 = cyc;
        step(0, 1, 8'h11, 0, 0, '0);
        step(0, 1, 8'h22, 0, 0, '0);
        step(0, 1, 8'h33, 1, 0, '0);
        idle(12);
        chk("r34_d0", 32'(obs_d[c0+8]),  32'h11);
        chk("r34_d1", 32'(obs_d[c0+9]),  32'h22);
        chk("r34_d2", 32'(obs_d[c0+10]), 32'h33);
        chk("r34_l",  32'({obs_l[c0+8], obs_l[c0+9], obs_l[c0+10]}), 32'b001);
        chk("r34_v7", 32'(obs_v[c0+7]),  32'd0);

        // Gap preservation.
        c0 = cyc;
        step(0, 1, 8'h44, 0, 0, '0);
        step(0, 0, 8'h99, 0, 0, '0);
        step(0, 1, 8'h55, 0, 0, '0);
        idle(10);
        chk("r35_v", 32'({obs_v[c0+8], obs_v[c0+9], obs_v[c0+10]}), 32'b101);
        chk("r35_gap", 32'(obs_d[c0+9]), 32'h00);

        // Depth change with five beats in flight.
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h60 + i), 0, 0, '0);
        c_ld = cyc;
        step(0, 0, 8'h00, 0, 1, 4'd2);
        ca = -1; n = 0;
        while (ca < 0 && n < 40) begin
            if (s_ready) ca = cyc;
            step(0, 1, 8'hA5, 0, 0, '0);
            n++;
        end
        chk("r36_timeout", 32'(ca >= 0), 32'd1);
        chk("r36_busy_len", 32'(ca - c_ld), 32'd10);
        idle(5);
        chk("r36_addr", 32'(sr_addr), 32'd2);
        chk("r36_v2", 32'(obs_v[ca+2]), 32'd0);
        chk("r36_v3", 32'(obs_v[ca+3]), 32'd1);
        chk("r36_d3", 32'(obs_d[ca+3]), 32'hA5);

        // Clamp, overwrite in DRAIN, load during APPLY.
        step(0, 0, 8'h00, 0, 1, 4'd15);
        idle(4);
        chk("r37_clamp", 32'(sr_addr), 32'd7);
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h70 + i), 0, 0, '0);
        step(0, 0, 8'h00, 0, 1, 4'd5);
        step(0, 0, 8'h00, 0, 1, 4'd1);
        idle(15);
        chk("r37_last", 32'(sr_addr), 32'd1);
        step(0, 1, 8'h81, 0, 1, 4'd4);
        n = 0;
        while (mode != M_APPLY && n < 20) begin idle(1); n++; end
        chk("r29_reach", 32'(mode == M_APPLY), 32'd1);
        step(0, 0, 8'h00, 0, 1, 4'd6);
        chk("r29_redrain", 32'(cfg_busy), 32'd1);
        idle(6);
        chk("r29_addr", 32'(sr_addr), 32'd6);

        // Reset in the middle of a drain.
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'hB0 + i), 0, 0, '0);
        step(0, 0, 8'h00, 0, 1, 4'd2);
        idle(2);
        step(1, 0, 8'h00, 0, 0, '0);
        chk("r38_mv",   32'(m_valid),  32'd0);
        chk("r38_rdy",  32'(s_ready),  32'd1);
        chk("r38_busy", 32'(cfg_busy), 32'd0);
        chk("r38_addr", 32'(sr_addr),  32'd7);
        c0 = cyc; cnt = 0;
        idle(20);
        for (int i = c0; i < c0 + 20; i++) cnt += int'(obs_v[i]);
        chk("r38_stale", 32'(cnt), 32'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, 8'($urandom),
                 1'($urandom), $urandom_range(0, 29) == 0, 4'($urandom));
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
